sprdma: RTL and testbench

Sprite DMA engine for the NES top level. It snoops the muxed CPU memory-controller bus for a write to $4014. On that trigger it stalls the CPU and copies the 256-byte page $XX00–$XXFF, one byte at a time, into PPU OAM through the $2004 register. Its bus outputs feed the existing cpumc/PPU address/data mux; its `active` output gates CPU `ready`.

---
 rtl/sprdma.sv | 93 +++++++++
 tb/tb_sprdma.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sprdma.sv
// Sprite DMA: on a CPU write to TRIG_ADDR, stalls the CPU and copies page
// {page,00..FF} byte by byte into OAM_ADDR via RD / LATCH / WR bus cycles.
module sprdma #(
    parameter logic [15:0] TRIG_ADDR = 16'h4014,
    parameter logic [15:0] OAM_ADDR  = 16'h2004
) (
    input  logic        clk,
    input  logic        nres,
    input  logic        en,
    input  logic [15:0] snoop_a,
    input  logic        snoop_r_nw,
    input  logic [7:0]  snoop_d,
    input  logic [7:0]  rd_d,
    output logic        active,
    output logic [15:0] dma_a,
    output logic        dma_r_nw,
    output logic [7:0]  dma_d
);

    typedef enum logic [1:0] {IDLE, RD, LATCH, WR} state_t;

    state_t     state, nstate;
    logic [7:0] page, npage;
    logic [7:0] idx, nidx;
    logic [7:0] data, ndata;
    logic       prev_hit;
    logic       hit;

    assign hit = (snoop_a == TRIG_ADDR) && !snoop_r_nw && en;

    always_comb begin
        nstate = state;
        npage  = page;
        nidx   = idx;
        ndata  = data;
        case (state)
            IDLE: if (hit && !prev_hit) begin
                nstate = RD;
                npage  = snoop_d;
                nidx   = 8'h00;
            end
            RD: if (en) nstate = LATCH;
            // A read completed while the debugger owned the bus is garbage,
            // so a freeze in LATCH falls back to RD and repeats the read.
            LATCH: if (en) begin
                nstate = WR;
                ndata  = rd_d;
            end else begin
                nstate = RD;
            end
            WR: if (en) begin
                if (idx == 8'hFF) begin
                    nstate = IDLE;
                end else begin
                    nstate = RD;
                    nidx   = 8'(idx + 8'd1);
                end
            end
            default: nstate = IDLE;
        endcase
    end

    // Bus outputs are registered from the next-state values, so nothing
    // combinational reaches the pins; a freeze blocks writes from the next cycle.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            state    <= IDLE;
            page     <= 8'h00;
            idx      <= 8'h00;
            data     <= 8'h00;
            prev_hit <= 1'b0;
            active   <= 1'b0;
            dma_a    <= 16'h0000;
            dma_r_nw <= 1'b1;
            dma_d    <= 8'h00;
        end else begin
            state    <= nstate;
            page     <= npage;
            idx      <= nidx;
            data     <= ndata;
            prev_hit <= hit;
            active   <= (nstate != IDLE);
            dma_r_nw <= !((nstate == WR) && en);
            dma_d    <= (nstate == WR) ? ndata : 8'h00;
            case (nstate)
                RD, LATCH: dma_a <= {npage, nidx};
                WR:        dma_a <= OAM_ADDR;
                default:   dma_a <= 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_sprdma.sv
// Bench for sprdma: RAM model with 1-cycle read latency, bus monitor, and a
// reference that expects each page byte written to $2004 in address order.
module tb_sprdma;

    logic        clk, nres, en;
    logic [15:0] snoop_a;
    logic        snoop_r_nw;
    logic [7:0]  snoop_d, rd_d;
    logic        active, dma_r_nw;
    logic [15:0] dma_a;
    logic [7:0]  dma_d;

    sprdma dut (
        .clk(clk), .nres(nres), .en(en),
        .snoop_a(snoop_a), .snoop_r_nw(snoop_r_nw), .snoop_d(snoop_d),
        .rd_d(rd_d), .active(active), .dma_a(dma_a),
        .dma_r_nw(dma_r_nw), .dma_d(dma_d)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    logic [7:0]  mem [0:65535];
    logic [15:0] wr_a_q[$];
    logic [7:0]  wr_d_q[$];
    logic [15:0] rd_q[$];
    int          act_cnt = 0;
    int          frz_wr  = 0;
    logic [16:0] last_rd = 17'h10000;
    int          checks  = 0;
    int          errors  = 0;

    // Synchronous RAM; returns junk while the debugger owns the bus.
    always @(posedge clk) rd_d <= en ? mem[dma_a] : 8'($urandom);

    always @(posedge clk) begin
        if (nres) begin
            if (!dma_r_nw) begin
                wr_a_q.push_back(dma_a);
                wr_d_q.push_back(dma_d);
            end
            if (active) act_cnt <= act_cnt + 1;
            if (!en && !dma_r_nw) frz_wr <= frz_wr + 1;
            if (active && dma_r_nw && dma_a != 16'h2004 && {1'b0, dma_a} != last_rd) begin
                rd_q.push_back(dma_a);
                last_rd <= {1'b0, dma_a};
            end
            if (!active) last_rd <= 17'h10000;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        snoop_a = 16'h0000; snoop_r_nw = 1'b1; snoop_d = 8'h00;
    endtask

    // CPU write of 'page' to address a, held for n cycles; ends in cycle k+n.
    task automatic cpu_wr(input logic [15:0] a, input logic r_nw, input logic [7:0] page, input int n);
        @(negedge clk);
        snoop_a = a; snoop_r_nw = r_nw; snoop_d = page;
        repeat (n) @(posedge clk);
        @(negedge clk);
        bus_idle();
    endtask

    task automatic wait_done(input string tag);
        int budget = 2000;
        while (active && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check(tag, 32'(active), 32'd0);
    endtask

    task automatic fill_page(input logic [7:0] page, input bit pattern);
        for (int i = 0; i < 256; i++)
            mem[{page, 8'(i)}] = pattern ? (8'(i) ^ 8'h5A) : 8'($urandom);
    endtask

    task automatic check_run(input string tag, input logic [7:0] page, input int exp_act,
                             input int wb, input int rb, input int ab);
        int bad_w = 0, bad_r = 0;
        check({tag, ".nwr"}, 32'(wr_a_q.size() - wb), 32'd256);
        check({tag, ".nrd"}, 32'(rd_q.size() - rb), 32'd256);
        for (int i = 0; i < 256; i++) begin
            if (wb + i >= wr_a_q.size() || wr_a_q[wb+i] !== 16'h2004 ||
                wr_d_q[wb+i] !== mem[{page, 8'(i)}]) bad_w++;
            if (rb + i >= rd_q.size() || rd_q[rb+i] !== {page, 8'(i)}) bad_r++;
        end
        check({tag, ".wrdata"}, 32'(bad_w), 32'd0);
        check({tag, ".rdaddr"}, 32'(bad_r), 32'd0);
        check({tag, ".actcyc"}, 32'(act_cnt - ab), 32'(exp_act));
    endtask

    initial begin
        int wb, rb, ab, fb;
        logic [7:0] pg;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        nres = 1'b0; en = 1'b1; bus_idle();

        // reset with random bus traffic
        repeat (4) begin
            @(negedge clk);
            snoop_a = 16'($urandom); snoop_r_nw = 1'($urandom); snoop_d = 8'($urandom);
            en = 1'($urandom);
        end
        snoop_a = 16'h4014; snoop_r_nw = 1'b0; en = 1'b1;
        @(negedge clk);
        check("rst.active", 32'(active), 32'd0);
        check("rst.r_nw", 32'(dma_r_nw), 32'd1);
        check("rst.a", 32'(dma_a), 32'h0000);
        check("rst.d", 32'(dma_d), 32'h00);
        bus_idle();
        @(negedge clk);
        nres = 1'b1;
        repeat (5) @(negedge clk);
        check("idle.active", 32'(active), 32'd0);
        check("idle.nwr", 32'(wr_a_q.size()), 32'd0);

        // basic copy of page 03
        fill_page(8'h03, 1'b1);
        wb = wr_a_q.size(); rb = rd_q.size(); ab = act_cnt;
        cpu_wr(16'h4014, 1'b0, 8'h03, 1);
        check("basic.start", 32'(active), 32'd1);
        check("basic.a0", 32'(dma_a), 32'h0300);
        check("basic.rnw0", 32'(dma_r_nw), 32'd1);
        check("basic.d0", 32'(dma_d), 32'h00);
        wait_done("basic.done");
        check_run("basic", 8'h03, 768, wb, rb, ab);

        // held trigger plus a second trigger mid-transfer
        fill_page(8'h07, 1'b0);
        wb = wr_a_q.size(); rb = rd_q.size(); ab = act_cnt;
        cpu_wr(16'h4014, 1'b0, 8'h03, 3);
        repeat (40) @(negedge clk);
        cpu_wr(16'h4014, 1'b0, 8'h07, 1);
        wait_done("held.done");
        check_run("held", 8'h03, 768, wb, rb, ab);
        repeat (10) @(negedge clk);
        check("held.norestart", 32'(active), 32'd0);

        // debugger freeze during LATCH of byte 5
        pg = 8'h20 + 8'($urandom_range(0, 31));
        fill_page(pg, 1'b0);
        wb = wr_a_q.size(); rb = rd_q.size(); ab = act_cnt; fb = frz_wr;
        cpu_wr(16'h4014, 1'b0, pg, 1);
        repeat (16) @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        check("frz.active", 32'(active), 32'd1);
        check("frz.nwr", 32'(wr_a_q.size() - wb), 32'd5);
        en = 1'b1;
        wait_done("frz.done");
        check_run("frz", pg, 779, wb, rb, ab);
        check("frz.nowrite", 32'(frz_wr - fb), 32'd0);

        // reset at byte 100, then restart
        pg = 8'h40 + 8'($urandom_range(0, 191));
        fill_page(pg, 1'b0);
        wb = wr_a_q.size();
        cpu_wr(16'h4014, 1'b0, pg, 1);
        repeat (300) @(negedge clk);
        nres = 1'b0;
        #1;
        check("mid.active", 32'(active), 32'd0);
        check("mid.rnw", 32'(dma_r_nw), 32'd1);
        repeat (3) @(negedge clk);
        nres = 1'b1;
        repeat (3) @(negedge clk);
        check("mid.nwr", 32'(wr_a_q.size() - wb), 32'd100);
        check("mid.idle", 32'(active), 32'd0);
        wb = wr_a_q.size(); rb = rd_q.size(); ab = act_cnt;
        cpu_wr(16'h4014, 1'b0, pg, 1);
        check("restart.a0", 32'(dma_a), {16'h0, pg, 8'h00});
        wait_done("restart.done");
        check_run("restart", pg, 768, wb, rb, ab);

        // non-trigger traffic
        wb = wr_a_q.size();
        cpu_wr(16'h4014, 1'b1, 8'h03, 2);
        cpu_wr(16'h4015, 1'b0, 8'h03, 2);
        repeat (5) @(negedge clk);
        check("notrig.active", 32'(active), 32'd0);
        check("notrig.nwr", 32'(wr_a_q.size() - wb), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
